riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu.sv | 267 ++++++++++++++++++++++++++
 tb/tb_riscv_lsu.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: RISC-V load/store unit with a single-outstanding bus master.
// Accepts one load or store from the core while idle, checks the funct
// and the alignment, then drives an aligned request with lane-shifted byte
// enables and write data. Load data is lane-selected and sign/zero-extended.
// A wait counter gives up on a bus that never answers.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   ld_en, st_en, funct        request pulse and RISC-V funct3
//   addr, wr_data              byte address, right-justified store data
//   stall                      busy (REQ or RESP)
//   done, rd_valid, rd_data    completion pulse, load-data pulse, load result
//   misaligned, bus_err        one-cycle fault pulses
//   m_req, m_we, m_addr, m_be, m_wdata   bus request channel
//   m_gnt, m_rvalid, m_rdata, m_err      bus response channel
module riscv_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic              st_en,
    input  logic [2:0]        funct,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wr_data,
    output logic              stall,
    output logic              done,
    output logic              rd_valid,
    output logic [XLEN-1:0]   rd_data,
    output logic              misaligned,
    output logic              bus_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [XLEN/8-1:0] m_be,
    output logic [XLEN-1:0]   m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [XLEN-1:0]   m_rdata,
    input  logic              m_err
);

    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic              is_ld_q,      is_ld_d;
    logic [2:0]        funct_q,      funct_d;
    logic [OFF_W-1:0]  off_q,        off_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              stall_q,      stall_d;
    logic              done_q,       done_d;
    logic              rd_valid_q,   rd_valid_d;
    logic [XLEN-1:0]   rd_data_q,    rd_data_d;
    logic              misaligned_q, misaligned_d;
    logic              bus_err_q,    bus_err_d;
    logic              m_req_q,      m_req_d;
    logic              m_we_q,       m_we_d;
    logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
    logic [BE_W-1:0]   m_be_q,       m_be_d;
    logic [XLEN-1:0]   m_wdata_q,    m_wdata_d;

    logic              illegal_c;
    logic              mis_c;
    logic [OFF_W-1:0]  off_c;
    logic [BE_W-1:0]   be_mask_c;
    logic [XLEN-1:0]   lane_c;
    logic [XLEN-1:0]   ext_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              timeout_c;

    // Request decode: legality, alignment and size mask from the core inputs.
    // On a simultaneous request the load wins, so decode as a load then.
    always_comb begin
        illegal_c = 1'b0;
        if (ld_en) begin
            illegal_c = (funct == 3'b111) ||
                        ((XLEN == 32) && ((funct == 3'b011) || (funct == 3'b110)));
        end else begin
            illegal_c = funct[2] || ((XLEN == 32) && (funct[1:0] == 2'b11));
        end

        mis_c     = 1'b0;
        be_mask_c = BE_W'(1);
        case (funct[1:0])
            2'b00: begin
                mis_c     = 1'b0;
                be_mask_c = BE_W'(4'h1);
            end
            2'b01: begin
                mis_c     = addr[0];
                be_mask_c = BE_W'(4'h3);
            end
            2'b10: begin
                mis_c     = (addr[1:0] != 2'b00);
                be_mask_c = BE_W'(4'hF);
            end
            default: begin
                mis_c     = (addr[2:0] != 3'b000);
                be_mask_c = '1;
            end
        endcase

        off_c = addr[OFF_W-1:0];
    end

    // Response lane select and extension, driven by the captured funct/offset.
    always_comb begin
        lane_c = m_rdata >> {off_q, 3'b000};
        case (funct_q)
            3'b000:  ext_c = XLEN'($signed(lane_c[7:0]));
            3'b001:  ext_c = XLEN'($signed(lane_c[15:0]));
            3'b010:  ext_c = XLEN'($signed(lane_c[31:0]));
            3'b100:  ext_c = XLEN'(lane_c[7:0]);
            3'b101:  ext_c = XLEN'(lane_c[15:0]);
            3'b110:  ext_c = XLEN'(lane_c[31:0]);
            default: ext_c = lane_c;
        endcase
    end

    // The counter value compared is the one this cycle would bring it to,
    // so TIMEOUT ungranted cycles in REQ/RESP end the transaction.
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign timeout_c = (TIMEOUT != 0) && (cnt_inc_c == CNT_W'(TIMEOUT));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        is_ld_d      = is_ld_q;
        funct_d      = funct_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_be_d       = m_be_q;
        m_wdata_d    = m_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (ld_en || st_en) begin
                    is_ld_d = ld_en;
                    funct_d = funct;
                    off_d   = off_c;
                    cnt_d   = '0;
                    if (illegal_c) begin
                        bus_err_d = 1'b1;
                    end else if (mis_c) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d   = S_REQ;
                        m_req_d   = 1'b1;
                        m_we_d    = ~ld_en;
                        m_addr_d  = addr & ~(ADDR_W'(BE_W - 1));
                        m_be_d    = be_mask_c << off_c;
                        m_wdata_d = wr_data << {off_c, 3'b000};
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc_c;
                if (m_gnt) begin
                    m_req_d = 1'b0;
                    if (is_ld_q) begin
                        state_d = S_RESP;
                    end else begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        bus_err_d = m_err;
                    end
                end else if (timeout_c) begin
                    m_req_d   = 1'b0;
                    bus_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RESP: begin
                cnt_d = cnt_inc_c;
                if (m_rvalid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (m_err) begin
                        bus_err_d = 1'b1;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = ext_c;
                    end
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                m_req_d = 1'b0;
            end
        endcase

        stall_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            is_ld_q      <= 1'b0;
            funct_q      <= 3'b000;
            off_q        <= '0;
            cnt_q        <= '0;
            stall_q      <= 1'b0;
            done_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_be_q       <= '0;
            m_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            is_ld_q      <= is_ld_d;
            funct_q      <= funct_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            done_q       <= done_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_be_q       <= m_be_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign stall      = stall_q;
    assign done       = done_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign m_req      = m_req_q;
    assign m_we       = m_we_q;
    assign m_addr     = m_addr_q;
    assign m_be       = m_be_q;
    assign m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed table-driven bench for riscv_lsu, with a 32-bit
// instance (TIMEOUT=4) and a 64-bit instance sharing the stimulus buses.
module tb_riscv_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ld_a, st_a, ld_b, st_b;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [63:0] wr_data;
    logic [63:0] m_rdata;
    logic        m_gnt, m_rvalid, m_err;

    logic        a_stall, a_done, a_rdv, a_mis, a_err, a_req, a_we;
    logic [31:0] a_rd, a_maddr, a_wd;
    logic [3:0]  a_be;
    logic        b_stall, b_done, b_rdv, b_mis, b_err, b_req, b_we;
    logic [63:0] b_rd, b_wd;
    logic [31:0] b_maddr;
    logic [7:0]  b_be;

    riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_a (
        .clk(clk), .reset(reset), .ld_en(ld_a), .st_en(st_a), .funct(funct),
        .addr(addr), .wr_data(wr_data[31:0]), .stall(a_stall), .done(a_done),
        .rd_valid(a_rdv), .rd_data(a_rd), .misaligned(a_mis), .bus_err(a_err),
        .m_req(a_req), .m_we(a_we), .m_addr(a_maddr), .m_be(a_be),
        .m_wdata(a_wd), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata[31:0]), .m_err(m_err)
    );

    riscv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) u_b (
        .clk(clk), .reset(reset), .ld_en(ld_b), .st_en(st_b), .funct(funct),
        .addr(addr), .wr_data(wr_data), .stall(b_stall), .done(b_done),
        .rd_valid(b_rdv), .rd_data(b_rd), .misaligned(b_mis), .bus_err(b_err),
        .m_req(b_req), .m_we(b_we), .m_addr(b_maddr), .m_be(b_be),
        .m_wdata(b_wd), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .m_err(m_err)
    );

    // Observation mux: sel picks which instance the checks look at.
    logic        sel;
    logic        o_stall, o_done, o_rdv, o_mis, o_err, o_req, o_we;
    logic [63:0] o_rd, o_wd;
    logic [31:0] o_maddr;
    logic [7:0]  o_be;
    assign o_stall = sel ? b_stall : a_stall;
    assign o_done  = sel ? b_done  : a_done;
    assign o_rdv   = sel ? b_rdv   : a_rdv;
    assign o_mis   = sel ? b_mis   : a_mis;
    assign o_err   = sel ? b_err   : a_err;
    assign o_req   = sel ? b_req   : a_req;
    assign o_we    = sel ? b_we    : a_we;
    assign o_rd    = sel ? b_rd    : {32'h0, a_rd};
    assign o_wd    = sel ? b_wd    : {32'h0, a_wd};
    assign o_maddr = sel ? b_maddr : a_maddr;
    assign o_be    = sel ? b_be    : {4'h0, a_be};

    typedef struct {
        bit          w64;
        bit          ld;
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wdata;
        logic [63:0] e_rd;
        bit          e_mis;
        bit          e_err;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_en();
        ld_a = 1'b0; st_a = 1'b0; ld_b = 1'b0; st_b = 1'b0;
    endtask

    // One zero-wait transaction (grant and rvalid held high throughout).
    task automatic run_vec(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d", i);
        sel = v.w64; funct = v.funct; addr = v.addr; wr_data = v.wdata;
        m_rdata = v.rdata; m_gnt = 1'b1; m_rvalid = 1'b1; m_err = 1'b0;
        if (v.w64) begin ld_b = v.ld; st_b = !v.ld; end
        else       begin ld_a = v.ld; st_a = !v.ld; end
        tick();
        clear_en();
        if (v.e_mis) begin
            chk({p, "_mis"},   64'(o_mis),   64'd1);
            chk({p, "_req0"},  64'(o_req),   64'd0);
            chk({p, "_stall"}, 64'(o_stall), 64'd0);
            chk({p, "_err0"},  64'(o_err),   64'd0);
        end else if (v.e_err) begin
            chk({p, "_err"},   64'(o_err),   64'd1);
            chk({p, "_req0"},  64'(o_req),   64'd0);
            chk({p, "_stall"}, 64'(o_stall), 64'd0);
            chk({p, "_mis0"},  64'(o_mis),   64'd0);
        end else begin
            chk({p, "_req"},   64'(o_req),   64'd1);
            chk({p, "_we"},    64'(o_we),    64'(!v.ld));
            chk({p, "_addr"},  64'(o_maddr), 64'(v.e_addr));
            chk({p, "_be"},    64'(o_be),    64'(v.e_be));
            chk({p, "_wdata"}, o_wd,         v.e_wdata);
            chk({p, "_stall"}, 64'(o_stall), 64'd1);
            tick();
            if (!v.ld) begin
                chk({p, "_done"},   64'(o_done),  64'd1);
                chk({p, "_req0"},   64'(o_req),   64'd0);
                chk({p, "_stall0"}, 64'(o_stall), 64'd0);
            end else begin
                chk({p, "_req0"},  64'(o_req),  64'd0);
                chk({p, "_done0"}, 64'(o_done), 64'd0);
                tick();
                chk({p, "_rdv"},    64'(o_rdv),   64'd1);
                chk({p, "_done"},   64'(o_done),  64'd1);
                chk({p, "_rd"},     o_rd,         v.e_rd);
                chk({p, "_stall0"}, 64'(o_stall), 64'd0);
            end
        end
        tick();
        chk({p, "_pulse_end"}, 64'({o_done, o_rdv, o_mis, o_err}), 64'd0);
    endtask

    initial begin
        //           w64   ld    fn      addr         wdata                  rdata                  e_addr       e_be   e_wdata                e_rd                   mis   err
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h103, 64'h0,                 64'h80FF_1234,         32'h100, 8'h08, 64'h0,                 64'hFFFF_FF80,         1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'b001, 32'h22,  64'hABCD,              64'h0,                 32'h20,  8'h0C, 64'hABCD_0000,         64'h0,                 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b010, 32'h41,  64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 64'h0,                 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b101, 32'h42,  64'h0,                 64'h80FF_1234,         32'h40,  8'h0C, 64'h0,                 64'h0000_80FF,         1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h40,  64'h0,                 64'h1234_8001,         32'h40,  8'h03, 64'h0,                 64'hFFFF_8001,         1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b100, 32'h101, 64'h0,                 64'h80FF_1234,         32'h100, 8'h02, 64'h0,                 64'h12,                1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 3'b000, 32'h7,   64'h1234_565A,         64'h0,                 32'h4,   8'h08, 64'h5A00_0000,         64'h0,                 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 3'b010, 32'h10,  64'hDEAD_BEEF,         64'h0,                 32'h10,  8'h0F, 64'hDEAD_BEEF,         64'h0,                 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b011, 32'h8,   64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 64'h0,                 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 3'b011, 32'h8,   64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 64'h0,                 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 3'b100, 32'h0,   64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 64'h0,                 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h44,  64'h0,                 64'h7654_3210,         32'h44,  8'h0F, 64'h0,                 64'h7654_3210,         1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 3'b001, 32'h23,  64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 64'h0,                 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'b111, 32'h0,   64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 64'h0,                 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 3'b110, 32'h0,   64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 64'h0,                 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 3'b110, 32'h14,  64'h0,                 64'hDEAD_BEEF_0000_0000, 32'h10, 8'hF0, 64'h0,                64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 3'b010, 32'h14,  64'h0,                 64'hDEAD_BEEF_0000_0000, 32'h10, 8'hF0, 64'h0,                64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 3'b011, 32'h28,  64'h0123_4567_89AB_CDEF, 64'h0,               32'h28,  8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0,               1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 3'b011, 32'h0C,  64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 64'h0,                 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 3'b001, 32'h0E,  64'hBEEF,              64'h0,                 32'h08,  8'hC0, 64'hBEEF_0000_0000_0000, 64'h0,               1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 3'b011, 32'h18,  64'h0,                 64'h8000_0000_0000_0001, 32'h18, 8'hFF, 64'h0,                64'h8000_0000_0000_0001, 1'b0, 1'b0};

        reset = 1'b0; sel = 1'b0; clear_en();
        funct = 3'b000; addr = '0; wr_data = '0; m_rdata = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_err = 1'b0;
        #12;
        chk("rst_a_outs", 64'({a_stall, a_done, a_rdv, a_mis, a_err, a_req, a_we}), 64'd0);
        chk("rst_a_bus",  64'(a_maddr | a_wd | {28'h0, a_be} | a_rd), 64'd0);
        chk("rst_b_outs", 64'({b_stall, b_done, b_rdv, b_mis, b_err, b_req, b_we}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Simultaneous load and store: the load is taken.
        sel = 1'b0; funct = 3'b010; addr = 32'h40; wr_data = 64'hFFFF;
        m_rdata = 64'h1122_3344; m_gnt = 1'b1; m_rvalid = 1'b1;
        ld_a = 1'b1; st_a = 1'b1;
        tick(); clear_en();
        chk("both_req", 64'(o_req), 64'd1);
        chk("both_we",  64'(o_we),  64'd0);
        tick(); tick();
        chk("both_rdv", 64'(o_rdv), 64'd1);
        chk("both_rd",  o_rd,       64'h1122_3344);
        tick();

        // Timeout: TIMEOUT=4 on the 32-bit instance, grant never comes.
        funct = 3'b101; addr = 32'h2; m_gnt = 1'b0; m_rvalid = 1'b0;
        ld_a = 1'b1;
        tick(); clear_en();
        chk("to_req_start", 64'(o_req), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("to_wait%0d", k), 64'({o_req, o_err, o_done}), 64'b100);
        end
        tick();
        chk("to_err",   64'(o_err),   64'd1);
        chk("to_done",  64'(o_done),  64'd1);
        chk("to_req0",  64'(o_req),   64'd0);
        chk("to_idle",  64'(o_stall), 64'd0);
        tick();
        chk("to_pulse", 64'({o_err, o_done}), 64'd0);

        // Late grant/rvalid while idle does nothing.
        m_gnt = 1'b1; m_rvalid = 1'b1;
        tick();
        chk("late_ignored", 64'({o_req, o_done, o_rdv, o_stall, o_err}), 64'd0);

        // Store with a bus error at grant.
        funct = 3'b010; addr = 32'h8; wr_data = 64'h1; m_err = 1'b1; st_a = 1'b1;
        tick(); clear_en();
        tick();
        chk("st_err_done", 64'(o_done), 64'd1);
        chk("st_err_err",  64'(o_err),  64'd1);
        m_err = 1'b0;
        tick();

        // Load with a bus error on rvalid keeps the previous rd_data.
        run_vec(100, vecs[5]);
        funct = 3'b000; addr = 32'h100; m_rdata = 64'hFFFF_FFFF; m_err = 1'b1;
        ld_a = 1'b1;
        tick(); clear_en();
        tick(); tick();
        chk("ld_err_done", 64'(o_done), 64'd1);
        chk("ld_err_err",  64'(o_err),  64'd1);
        chk("ld_err_rdv0", 64'(o_rdv),  64'd0);
        chk("ld_err_hold", o_rd,        64'h12);
        m_err = 1'b0;
        tick();

        // Reset while waiting in RESP, then a new LW right after release.
        funct = 3'b010; addr = 32'h48; m_gnt = 1'b1; m_rvalid = 1'b0;
        m_rdata = 64'h55; ld_a = 1'b1;
        tick(); clear_en();
        tick();
        chk("resp_stall", 64'(o_stall), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({a_stall, a_done, a_rdv, a_mis, a_err, a_req, a_we}), 64'd0);
        chk("mid_rst_bus",  64'(a_maddr | a_wd | {28'h0, a_be}), 64'd0);
        chk("mid_rst_rd",   64'(a_rd), 64'd0);
        funct = 3'b010; addr = 32'h44; m_rvalid = 1'b1; m_rdata = 64'h0A0B_0C0D;
        ld_a = 1'b1;
        #2 reset = 1'b1;
        chk("rel_no_done", 64'(o_done), 64'd0);
        tick(); clear_en();
        chk("rel_req",  64'(o_req),   64'd1);
        chk("rel_addr", 64'(o_maddr), 64'h44);
        tick();
        chk("rel_no_done2", 64'(o_done), 64'd0);
        tick();
        chk("rel_rdv", 64'(o_rdv), 64'd1);
        chk("rel_rd",  o_rd,       64'h0A0B_0C0D);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
